// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - issue, CDB, ALU and broadcast bus of the ALU reservation station
interface alu_rs_if #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 2
) ();
    logic                 rdy_in;
    logic                 clear;
    logic                 issue_valid;
    logic [3:0]           issue_op;
    logic                 issue_qj_busy;
    logic [ROB_WIDTH-1:0] issue_qj;
    logic [31:0]          issue_vj;
    logic                 issue_qk_busy;
    logic [ROB_WIDTH-1:0] issue_qk;
    logic [31:0]          issue_vk;
    logic [ROB_WIDTH-1:0] issue_rob;
    logic                 rs_full;
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_rob;
    logic [31:0]          cdb_value;
    logic                 alu_cal;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [3:0]           alu_op;
    logic [RS_WIDTH-1:0]  alu_index;
    logic                 alu_done;
    logic [RS_WIDTH-1:0]  alu_done_index;
    logic [31:0]          alu_result;
    logic                 out_valid;
    logic [ROB_WIDTH-1:0] out_rob;
    logic [31:0]          out_value;

    modport master (
        output rdy_in, clear, issue_valid, issue_op, issue_qj_busy, issue_qj, issue_vj,
               issue_qk_busy, issue_qk, issue_vk, issue_rob, cdb_valid, cdb_rob, cdb_value,
               alu_done, alu_done_index, alu_result,
        input  rs_full, alu_cal, alu_a, alu_b, alu_op, alu_index, out_valid, out_rob, out_value
    );

    modport slave (
        input  rdy_in, clear, issue_valid, issue_op, issue_qj_busy, issue_qj, issue_vj,
               issue_qk_busy, issue_qk, issue_vk, issue_rob, cdb_valid, cdb_rob, cdb_value,
               alu_done, alu_done_index, alu_result,
        output rs_full, alu_cal, alu_a, alu_b, alu_op, alu_index, out_valid, out_rob, out_value
    );
endinterface

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - ALU reservation station; define ALU_RS_PERF_EN for dispatch/full counters
module alu_rs #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
`ifdef ALU_RS_PERF_EN
    output logic [31:0] perf_dispatch,
    output logic [31:0] perf_full,
`endif
    alu_rs_if.slave     bus
);
    localparam int RS_SIZE = 1 << RS_WIDTH;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_EXEC} state_t;

    state_t               state  [RS_SIZE];
    logic [3:0]           op_q   [RS_SIZE];
    logic                 busy_j [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj     [RS_SIZE];
    logic [31:0]          vj     [RS_SIZE];
    logic                 busy_k [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk     [RS_SIZE];
    logic [31:0]          vk     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob    [RS_SIZE];

    logic                 pend_valid;
    logic [RS_WIDTH-1:0]  pend_index;
    logic [31:0]          pend_result;

    logic                 alu_cal_q;
    logic [31:0]          alu_a_q;
    logic [31:0]          alu_b_q;
    logic [3:0]           alu_op_q;
    logic [RS_WIDTH-1:0]  alu_index_q;
    logic                 out_valid_q;
    logic [ROB_WIDTH-1:0] out_rob_q;
    logic [31:0]          out_value_q;

    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_rob;
    logic [31:0]          cdb_value;

    logic                 free_found;
    logic [RS_WIDTH-1:0]  free_idx;
    logic                 ready_found;
    logic [RS_WIDTH-1:0]  ready_idx;

    assign cdb_valid = bus.cdb_valid;
    assign cdb_rob   = bus.cdb_rob;
    assign cdb_value = bus.cdb_value;

    assign bus.rs_full   = ~free_found;
    assign bus.alu_cal   = alu_cal_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_index = alu_index_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rob   = out_rob_q;
    assign bus.out_value = out_value_q;

    // Operand capture from either broadcast bus; the external CDB is checked last so it wins.
    function automatic logic [32:0] snoop(input logic busy, input logic [ROB_WIDTH-1:0] tag,
                                          input logic [31:0] val);
        logic [32:0] res;
        res = {busy, val};
        if (busy && out_valid_q && (out_rob_q == tag))
            res = {1'b0, out_value_q};
        if (busy && cdb_valid && (cdb_rob == tag))
            res = {1'b0, cdb_value};
        return res;
    endfunction

    // Lowest-index FREE entry for issue and lowest-index ready WAIT entry for dispatch.
    always_comb begin
        free_found  = 1'b0;
        free_idx    = '0;
        ready_found = 1'b0;
        ready_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (state[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = RS_WIDTH'(i);
            end
            if ((state[i] == ST_WAIT) && !busy_j[i] && !busy_k[i]) begin
                ready_found = 1'b1;
                ready_idx   = RS_WIDTH'(i);
            end
        end
    end

    // Entry lifecycle: issue, operand wakeup, dispatch, completion broadcast and stall buffering.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                state[i]  <= ST_FREE;
                op_q[i]   <= '0;
                busy_j[i] <= 1'b0;
                qj[i]     <= '0;
                vj[i]     <= '0;
                busy_k[i] <= 1'b0;
                qk[i]     <= '0;
                vk[i]     <= '0;
                rob[i]    <= '0;
            end
            pend_valid  <= 1'b0;
            pend_index  <= '0;
            pend_result <= '0;
            alu_cal_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_index_q <= '0;
            out_valid_q <= 1'b0;
            out_rob_q   <= '0;
            out_value_q <= '0;
        end else if (!bus.rdy_in) begin
            // Stalled: only an in-flight ALU result is parked for later broadcast.
            alu_cal_q <= 1'b0;
            if (bus.alu_done) begin
                pend_valid  <= 1'b1;
                pend_index  <= bus.alu_done_index;
                pend_result <= bus.alu_result;
            end
        end else if (bus.clear) begin
            for (int i = 0; i < RS_SIZE; i++)
                state[i] <= ST_FREE;
            alu_cal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            pend_valid  <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (state[i] == ST_WAIT) begin
                    {busy_j[i], vj[i]} <= snoop(busy_j[i], qj[i], vj[i]);
                    {busy_k[i], vk[i]} <= snoop(busy_k[i], qk[i], vk[i]);
                end
            end

            if (bus.issue_valid && free_found) begin
                state[free_idx] <= ST_WAIT;
                op_q[free_idx]  <= bus.issue_op;
                qj[free_idx]    <= bus.issue_qj;
                qk[free_idx]    <= bus.issue_qk;
                rob[free_idx]   <= bus.issue_rob;
                {busy_j[free_idx], vj[free_idx]} <= snoop(bus.issue_qj_busy, bus.issue_qj, bus.issue_vj);
                {busy_k[free_idx], vk[free_idx]} <= snoop(bus.issue_qk_busy, bus.issue_qk, bus.issue_vk);
            end

            alu_cal_q <= ready_found;
            if (ready_found) begin
                alu_a_q          <= vj[ready_idx];
                alu_b_q          <= vk[ready_idx];
                alu_op_q         <= op_q[ready_idx];
                alu_index_q      <= ready_idx;
                state[ready_idx] <= ST_EXEC;
            end

            if (pend_valid) begin
                out_valid_q       <= 1'b1;
                out_rob_q         <= rob[pend_index];
                out_value_q       <= pend_result;
                state[pend_index] <= ST_FREE;
                pend_valid        <= 1'b0;
            end else if (bus.alu_done) begin
                out_valid_q                 <= 1'b1;
                out_rob_q                   <= rob[bus.alu_done_index];
                out_value_q                 <= bus.alu_result;
                state[bus.alu_done_index]   <= ST_FREE;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_RS_PERF_EN
    // Dispatch and full-occupancy counters; cleared only by reset, wrap naturally.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            perf_dispatch <= '0;
            perf_full     <= '0;
        end else if (bus.rdy_in) begin
            if (!bus.clear && ready_found)
                perf_dispatch <= perf_dispatch + 32'd1;
            if (!free_found)
                perf_full <= perf_full + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu_rs.sv
// tb/tb_alu_rs.sv - scoreboard bench for the ALU reservation station
module tb_alu_rs;
    localparam int ROB_WIDTH = 4;
    localparam int RS_WIDTH  = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    alu_rs_if #(.ROB_WIDTH(ROB_WIDTH), .RS_WIDTH(RS_WIDTH)) bus ();

`ifdef ALU_RS_PERF_EN
    logic [31:0] perf_dispatch;
    logic [31:0] perf_full;
`endif

    alu_rs #(.ROB_WIDTH(ROB_WIDTH), .RS_WIDTH(RS_WIDTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
`ifdef ALU_RS_PERF_EN
        .perf_dispatch (perf_dispatch),
        .perf_full     (perf_full),
`endif
        .bus           (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [1:0]  idx;
    } disp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  rob;
        logic [31:0] val;
    } bc_t;

    disp_t dq[$];
    bc_t   bq[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic  rdy_q = 1'b0;
    logic  rst_q = 1'b0;

    always @(posedge clk_in) begin
        cyc   <= cyc + 1;
        rdy_q <= bus.rdy_in;
        rst_q <= rst_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // ALU model: answers every alu_cal pulse one cycle later
    initial begin
        logic        c;
        logic [1:0]  i;
        logic [31:0] r;
        bus.alu_done       = 1'b0;
        bus.alu_done_index = '0;
        bus.alu_result     = '0;
        forever begin
            @(negedge clk_in);
            c = bus.alu_cal;
            i = bus.alu_index;
            r = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
            @(posedge clk_in);
            #1;
            bus.alu_done       = (c === 1'b1);
            bus.alu_done_index = i;
            bus.alu_result     = r;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT dispatches or broadcasts
    initial begin
        disp_t d;
        bc_t   b;
        forever begin
            @(negedge clk_in);
            if (bus.alu_cal === 1'b1) begin
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dispatch: got idx=%0d a=%h b=%h at cycle %0d, want none",
                             bus.alu_index, bus.alu_a, bus.alu_b, cyc);
                end else begin
                    d = dq.pop_front();
                    check("disp_cycle", 32'(cyc), 32'(d.cyc));
                    check("disp_a", bus.alu_a, d.a);
                    check("disp_b", bus.alu_b, d.b);
                    check("disp_op", 32'(bus.alu_op), 32'(d.op));
                    check("disp_index", 32'(bus.alu_index), 32'(d.idx));
                end
            end
            if (rdy_q && rst_q && (bus.out_valid === 1'b1)) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_broadcast: got rob=%0d value=%h at cycle %0d, want none",
                             bus.out_rob, bus.out_value, cyc);
                end else begin
                    b = bq.pop_front();
                    check("bc_cycle", 32'(cyc), 32'(b.cyc));
                    check("bc_rob", 32'(bus.out_rob), 32'(b.rob));
                    check("bc_value", bus.out_value, b.val);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
            bus.issue_valid = 1'b0;
            bus.cdb_valid   = 1'b0;
            bus.clear       = 1'b0;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic bj, input logic [3:0] qj, input logic [31:0] vj,
                         input logic bk, input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] rob);
        bus.issue_valid   = 1'b1;
        bus.issue_op      = op;
        bus.issue_qj_busy = bj;
        bus.issue_qj      = qj;
        bus.issue_vj      = vj;
        bus.issue_qk_busy = bk;
        bus.issue_qk      = qk;
        bus.issue_vk      = vk;
        bus.issue_rob     = rob;
    endtask

    task automatic cdb(input logic [3:0] rob, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = rob;
        bus.cdb_value = val;
    endtask

    task automatic exp_disp(input int c, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [1:0] idx);
        disp_t d;
        d.cyc = c; d.a = a; d.b = b; d.op = op; d.idx = idx;
        dq.push_back(d);
    endtask

    task automatic exp_bc(input int c, input logic [3:0] rob, input logic [31:0] val);
        bc_t b;
        b.cyc = c; b.rob = rob; b.val = val;
        bq.push_back(b);
    endtask

    initial begin
        int k;
        rst_in            = 1'b0;
        bus.rdy_in        = 1'b1;
        bus.clear         = 1'b0;
        bus.issue_valid   = 1'b0;
        bus.issue_op      = '0;
        bus.issue_qj_busy = 1'b0;
        bus.issue_qj      = '0;
        bus.issue_vj      = '0;
        bus.issue_qk_busy = 1'b0;
        bus.issue_qk      = '0;
        bus.issue_vk      = '0;
        bus.issue_rob     = '0;
        bus.cdb_valid     = 1'b0;
        bus.cdb_rob       = '0;
        bus.cdb_value     = '0;
        step(3);

        check("rst_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rs_full", 32'(bus.rs_full), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_index", 32'(bus.alu_index), 32'd0);
        check("rst_out_rob", 32'(bus.out_rob), 32'd0);
        check("rst_out_value", bus.out_value, 32'd0);
        rst_in = 1'b1;
        step(1);

        // ADD 5+7, both operands ready
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        exp_disp(k + 2, 32'd5, 32'd7, 4'd0, 2'd0);
        exp_bc(k + 4, 4'd3, 32'd12);
        step(6);

        // SUB waiting on tag 2, woken by external CDB three cycles later
        k = cyc;
        issue(4'd1, 1'b1, 4'd2, 32'hdead_beef, 1'b0, 4'd0, 32'd1, 4'd4);
        exp_disp(k + 5, 32'd10, 32'd1, 4'd1, 2'd0);
        exp_bc(k + 7, 4'd4, 32'd9);
        step(3);
        cdb(4'd2, 32'd10);
        step(6);

        // Issue bypass from the external CDB
        k = cyc;
        issue(4'd0, 1'b1, 4'd6, 32'h0000_1234, 1'b0, 4'd0, 32'h10, 4'd5);
        cdb(4'd6, 32'h55);
        exp_disp(k + 2, 32'h55, 32'h10, 4'd0, 2'd0);
        exp_bc(k + 4, 4'd5, 32'h65);
        step(6);

        // Issue bypass from the station's own broadcast
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd7);
        exp_disp(k + 2, 32'd1, 32'd2, 4'd0, 2'd0);
        exp_bc(k + 4, 4'd7, 32'd3);
        step(4);
        issue(4'd0, 1'b1, 4'd7, 32'h0000_ffff, 1'b0, 4'd0, 32'd4, 4'd8);
        exp_disp(k + 6, 32'd3, 32'd4, 4'd0, 2'd0);
        exp_bc(k + 8, 4'd8, 32'd7);
        step(6);

        // Fill all four entries, drop a fifth issue, wake entries 0 and 2 together
        issue(4'd0, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd1, 4'd0);
        step(1);
        issue(4'd0, 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd2, 4'd1);
        step(1);
        issue(4'd1, 1'b0, 4'd0, 32'd100, 1'b1, 4'd9, 32'd0, 4'd2);
        step(1);
        issue(4'd0, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd3, 4'd3);
        step(1);
        check("full_after_fill", 32'(bus.rs_full), 32'd1);
        issue(4'd0, 1'b0, 4'd0, 32'd50, 1'b0, 4'd0, 32'd60, 4'd13);
        step(1);
        check("full_after_ignored_issue", 32'(bus.rs_full), 32'd1);
        k = cyc;
        cdb(4'd9, 32'd20);
        exp_disp(k + 2, 32'd20, 32'd1, 4'd0, 2'd0);
        exp_disp(k + 3, 32'd100, 32'd20, 4'd1, 2'd2);
        exp_bc(k + 4, 4'd0, 32'd21);
        exp_bc(k + 5, 4'd2, 32'd80);
        step(3);
        check("full_while_exec", 32'(bus.rs_full), 32'd1);
        step(1);
        check("not_full_after_free", 32'(bus.rs_full), 32'd0);
        step(3);

        // Clear with entries in WAIT (1, 3, a ready 1) and EXEC (0)
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd14);
        exp_disp(k + 2, 32'd1, 32'd1, 4'd0, 2'd0);
        step(2);
        cdb(4'd10, 32'd77);
        step(1);
        bus.clear = 1'b1;
        issue(4'd0, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 32'd9, 4'd15);
        step(1);
        check("clear_rs_full", 32'(bus.rs_full), 32'd0);
        check("clear_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("clear_out_valid", 32'(bus.out_valid), 32'd0);
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 32'd3, 4'd15);
        exp_disp(k + 2, 32'd2, 32'd3, 4'd0, 2'd0);
        exp_bc(k + 4, 4'd15, 32'd5);
        step(1);
        cdb(4'd12, 32'd5);
        step(6);

        // Stall for three cycles while the ALU result arrives
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd30, 1'b0, 4'd0, 32'd12, 4'd6);
        exp_disp(k + 2, 32'd30, 32'd12, 4'd0, 2'd0);
        step(2);
        issue(4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd11);
        step(1);
        bus.rdy_in = 1'b0;
        step(1);
        check("stall1_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("stall1_out_valid", 32'(bus.out_valid), 32'd0);
        bus.clear = 1'b1;
        step(1);
        check("stall2_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("stall2_out_valid", 32'(bus.out_valid), 32'd0);
        step(1);
        check("stall3_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("stall3_out_valid", 32'(bus.out_valid), 32'd0);
        bus.rdy_in = 1'b1;
        exp_bc(k + 7, 4'd6, 32'd42);
        exp_disp(k + 7, 32'd1, 32'd2, 4'd0, 2'd1);
        exp_bc(k + 9, 4'd11, 32'd3);
        step(6);

        // Reset with a result in flight
        k = cyc;
        issue(4'd0, 1'b0, 4'd0, 32'd4, 1'b0, 4'd0, 32'd4, 4'd2);
        exp_disp(k + 2, 32'd4, 32'd4, 4'd0, 2'd0);
        step(3);
        rst_in = 1'b0;
        step(1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_alu_cal", 32'(bus.alu_cal), 32'd0);
        check("midrst_rs_full", 32'(bus.rs_full), 32'd0);
        rst_in = 1'b1;
        step(5);

        check("disp_queue_drained", 32'(dq.size()), 32'd0);
        check("bc_queue_drained", 32'(bq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that issues work to the integer ALU and collects its results.
- Holds up to 2^RS_WIDTH renamed ALU/branch ops from the decoder.
- Snoops the common data bus (CDB) until both operands are valid, then dispatches one ready entry per cycle to the ALU.
- Captures the ALU's indexed completion, broadcasts result and ROB tag on its own CDB port, and frees the entry.

Parameters:
ROB_WIDTH, 4, ROB tag width
RS_WIDTH, 2, entry index width; RS_SIZE = 2^RS_WIDTH entries

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_in  in  1  synchronous reset, active-low
rdy_in  in  1  global ready; low = stall
clear  in  1  flush (mispredict); effective only when rdy_in high
issue_valid  in  1  new op this cycle
issue_op  in  4  ALU opcode (ADD..BNE encoding shared with ALU)
issue_qj_busy  in  1  operand j awaits producer
issue_qj  in  ROB_WIDTH  producer tag of j
issue_vj  in  32  value of j when not busy
issue_qk_busy  in  1  operand k awaits producer
issue_qk  in  ROB_WIDTH  producer tag of k
issue_vk  in  32  value of k when not busy
issue_rob  in  ROB_WIDTH  destination ROB tag
rs_full  out  1  no FREE entry (combinational)
cdb_valid  in  1  external broadcast (e.g. load unit)
cdb_rob  in  ROB_WIDTH  external broadcast tag
cdb_value  in  32  external broadcast value
alu_cal  out  1  ALU compute request
alu_a  out  32  operand a (Vj)
alu_b  out  32  operand b (Vk)
alu_op  out  4  opcode
alu_index  out  RS_WIDTH  dispatched entry index
alu_done  in  1  ALU result valid (ALU to_rs)
alu_done_index  in  RS_WIDTH  entry index echoed by ALU
alu_result  in  32  ALU result
out_valid  out  1  own CDB broadcast valid
out_rob  out  ROB_WIDTH  broadcast tag
out_value  out  32  broadcast value

Behaviour:
- Entry states: FREE -> WAIT (issued) -> EXEC (dispatched) -> FREE (result broadcast). Each entry holds op, Vj/Qj/busy_j, Vk/Qk/busy_k, rob.
- Reset (rst_in low at an edge): all entries FREE; alu_cal=0; out_valid=0; pend_valid=0; alu_a/alu_b/alu_op/alu_index/out_rob/out_value=0.
- Issue: when issue_valid and !rs_full, the lowest-index FREE entry becomes WAIT. Issue while full is ignored.
- Issue bypass: if an issued operand is busy and its tag matches a valid cdb_rob or out_rob in the same cycle, capture that value and store it not busy.
- Wakeup: every WAIT entry compares busy Qj/Qk against cdb_* and out_* each cycle and captures on match. If both buses match, cdb_value wins (tags are unique, so this is defensive only).
- Dispatch: each rdy cycle, the lowest-index WAIT entry with both operands valid at the start of the cycle is registered onto alu_a/b/op/index with alu_cal=1, and the entry moves to EXEC.
  - alu_cal=0 when nothing is ready; it is a per-cycle pulse, not held.
  - An entry woken or issued at edge N dispatches at edge N+1 at the earliest.
- Latency: alu_cal high in cycle C; alu_done in cycle C+1; out_valid in cycle C+2. Best case issue to broadcast is 3 cycles.
- Completion: on alu_done, register out_valid=1, out_rob=rob[alu_done_index], out_value=alu_result, and free the entry. Otherwise out_valid=0.
  - An entry freed at an edge may be reissued in the next cycle (rs_full drops in the cycle after completion).
- rdy_in low:
  - No issue, wakeup, dispatch or freeing. alu_cal is forced 0 at the next edge. out_* registers hold their value.
  - An alu_done arriving during the stall is latched into a one-deep pend buffer (pend_valid, index, result).
  - On the first edge with rdy_in high, pend is broadcast and its entry freed; pend has priority over an alu_done in that cycle, which cannot occur because alu_cal was 0.
- clear (with rdy_in): all entries FREE, alu_cal=0, out_valid=0, pend_valid=0; issue and alu_done in that cycle are dropped. clear with rdy_in low has no effect.
- Reset mid-operation: same as reset; in-flight ALU results are discarded.

Optional Feature:
- Macro ALU_RS_PERF_EN.
- Defined: adds outputs perf_dispatch[31:0] (counts alu_cal pulses) and perf_full[31:0] (counts rdy cycles with rs_full high). Both are zero on reset, not cleared by clear, and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Issue ADD, vj=5, vk=7, both not busy, rob=3 -> alu_cal next cycle with a=5, b=7, op=0000; out_valid 2 cycles later with out_rob=3, out_value=12 (using ALU model).
- Issue SUB with qj_busy, qj=2, vk=1; cdb_valid rob=2 value=10 three cycles later -> dispatch the cycle after wakeup with a=10; broadcast value 9.
- Issue with qj=6 in the same cycle as cdb rob=6 value=0x55 -> bypass captured; dispatch next cycle with a=0x55.
- Fill all 4 entries with blocked ops -> rs_full=1; a 5th issue is ignored; wake entries 2 and 0 together -> entry 0 dispatches first, then entry 2.
- Dispatch, then drop rdy_in for 3 cycles while alu_done arrives -> alu_cal forced 0, no broadcast during the stall; broadcast on first rdy cycle with correct tag.
- Entries in WAIT and EXEC, assert clear with rdy_in=1 -> rs_full=0, alu_cal=0, out_valid=0 next cycle; issue accepted into entry 0 afterwards.
